// File: rtl/mem_arb.sv
// Serializes instruction-fetch and data accesses onto one single-port memory.
// state  | meaning
// IDLE   | arbitrate between if_req and dm_req, latch the winner's request
// ACCESS | one-cycle memory strobe driven from the latched request
// WAIT   | count read latency, capture mem_rdata for the owner
// RESP   | one-cycle ack to the owner
module mem_arb #(
  parameter int AW     = 16,
  parameter int DW     = 32,
  parameter int RD_LAT = 2,
  parameter int STARVE = 3
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE);
  localparam logic [2:0] LAT_LAST   = 3'(RD_LAT);

  state_t        state, state_nxt;
  logic          we_q, we_nxt;
  logic [3:0]    starve_cnt, starve_nxt;
  logic [2:0]    wait_cnt, wait_nxt;
  logic          fetch_win;
  logic          if_ack_nxt, dm_ack_nxt, mem_en_nxt, mem_we_nxt, busy_nxt, owner_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt, if_rdata_nxt, dm_rdata_nxt;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      busy       <= 1'b0;
      owner      <= 1'b0;
    end else begin
      state      <= state_nxt;
      we_q       <= we_nxt;
      starve_cnt <= starve_nxt;
      wait_cnt   <= wait_nxt;
      if_ack     <= if_ack_nxt;
      dm_ack     <= dm_ack_nxt;
      mem_en     <= mem_en_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      if_rdata   <= if_rdata_nxt;
      dm_rdata   <= dm_rdata_nxt;
      busy       <= busy_nxt;
      owner      <= owner_nxt;
    end
  end

  // mem_addr/mem_wdata double as the latched request; they hold after ACCESS.
  always_comb begin
    state_nxt     = state;
    we_nxt        = we_q;
    starve_nxt    = starve_cnt;
    wait_nxt      = wait_cnt;
    fetch_win     = 1'b0;
    if_ack_nxt    = 1'b0;
    dm_ack_nxt    = 1'b0;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_rdata_nxt  = if_rdata;
    dm_rdata_nxt  = dm_rdata;
    owner_nxt     = owner;
    case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          fetch_win = if_req && (!dm_req || starve_cnt == STARVE_MAX);
          if (fetch_win) begin
            we_nxt       = 1'b0;
            mem_addr_nxt = if_addr;
            owner_nxt    = 1'b0;
            starve_nxt   = '0;
          end else begin
            we_nxt        = dm_we;
            mem_addr_nxt  = dm_addr;
            mem_wdata_nxt = dm_wdata;
            owner_nxt     = 1'b1;
            if (!if_req)
              starve_nxt = '0;
            else if (starve_cnt != STARVE_MAX)
              starve_nxt = starve_cnt + 4'd1;
          end
          mem_en_nxt = 1'b1;
          mem_we_nxt = we_nxt;
          state_nxt  = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          if_ack_nxt = !owner;
          dm_ack_nxt = owner;
          state_nxt  = RESP;
        end else begin
          wait_nxt  = 3'd1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == LAT_LAST) begin
          if (owner) dm_rdata_nxt = mem_rdata;
          else       if_rdata_nxt = mem_rdata;
          if_ack_nxt = !owner;
          dm_ack_nxt = owner;
          state_nxt  = RESP;
        end else begin
          wait_nxt = wait_cnt + 3'd1;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end
endmodule

// File: doc/mem_arb.md
# mem_arb

Shared-memory arbiter and sequencer for the SISC core. It time-multiplexes one single-port unified memory between the instruction-fetch path (IR load) and the data path (LOD/STR/SWP). It uses a req/ack handshake on each requester side and a fixed-latency read protocol on the memory side. It sits between the control/datapath and the memory macro, so fetch and data accesses are serialized without changing the memory.

## Interface

Parameters:
- AW, 16, address width.
- DW, 32, data width.
- RD_LAT, 2, memory read latency in cycles, legal range 1..7.
- STARVE, 3, maximum consecutive data grants while fetch waits, legal range 1..15.

Ports:
- clk, input, 1, rising-edge clock.
- rst_f, input, 1, asynchronous active-low reset.
- if_req, input, 1, fetch request, held until if_ack.
- if_addr, input, AW, fetch address.
- if_ack, output, 1, one-cycle fetch completion pulse.
- if_rdata, output, DW, fetched word, registered.
- dm_req, input, 1, data request, held until dm_ack.
- dm_we, input, 1, 1 = store, 0 = load.
- dm_addr, input, AW, data address.
- dm_wdata, input, DW, store data.
- dm_ack, output, 1, one-cycle data completion pulse.
- dm_rdata, output, DW, loaded word, registered.
- mem_en, output, 1, memory access strobe.
- mem_we, output, 1, memory write enable.
- mem_addr, output, AW, memory address.
- mem_wdata, output, DW, memory write data.
- mem_rdata, input, DW, memory read data.
- busy, output, 1, high when state is not IDLE.
- owner, output, 1, port of the current or last grant: 0 = fetch, 1 = data.

## Operation

- **States:** IDLE, ACCESS, WAIT, RESP. All outputs are registered.
- **IDLE:** arbitrate if either req is high.
  - Grant latches addr, we and wdata into internal registers and sets owner. The fetch port always has we = 0.
  - Next state is ACCESS.
- **Arbitration:**
  - Data has priority.
  - Exception: grant fetch when if_req = 1 and starve_cnt == STARVE.
- **starve_cnt (4 bits):**
  - Increments on a data grant while if_req = 1.
  - Clears on any fetch grant.
  - Clears on a data grant while if_req = 0.
  - Saturates at STARVE.
- **ACCESS (1 cycle):** mem_en = 1, mem_we = latched we, mem_addr and mem_wdata = latched values.
  - Write goes to RESP.
  - Read goes to WAIT with wait_cnt = 1.
- **WAIT:** mem_en = 0.
  - When wait_cnt == RD_LAT, capture mem_rdata into the owner's rdata register and go to RESP.
  - Otherwise wait_cnt increments.
- **RESP (1 cycle):** the owner's ack = 1, then go to IDLE.
- **rdata registers:** the non-owner's rdata is never modified. Writes never modify any rdata. Each rdata register holds its value until its next read capture.
- **Requests outside IDLE:** a req asserted while not IDLE is not sampled until the state returns to IDLE.
- **Requester rule:** deassert req in the cycle after ack. The arbiter never re-grants in the RESP cycle.
- **Address stability:** requester addr and wdata may change after the grant, because latched copies drive memory.
- **Simultaneous req** with starve_cnt < STARVE: data wins and if_req waits.
- **Reset** (rst_f low, asynchronous, including mid-transaction):
  - State goes to IDLE.
  - mem_en, mem_we, if_ack, dm_ack, busy and owner go to 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata, starve_cnt and wait_cnt go to 0.
  - Any in-flight transaction is dropped and no ack is issued for it.
  - After release, the first rising edge with a req high grants normally.

## Timing

- Cycle 0 is the IDLE cycle in which the winning req is sampled high.
- Write: ACCESS in cycle 1, ack in cycle 2. Back-to-back throughput is 1 write per 3 cycles.
- Read: ACCESS in cycle 1, WAIT in cycles 2..RD_LAT+1, ack in cycle RD_LAT+2.
  - With RD_LAT = 2, ack is in cycle 4.
  - rdata is valid in the ack cycle and holds afterwards.
- Memory contract: mem_rdata is valid in cycle ACCESS+RD_LAT and is sampled at the end of that cycle.
- busy is high from cycle 1 through the ack cycle inclusive.
- mem_en is a single-cycle pulse per transaction. There is never more than one transaction outstanding.

## Test plan

- **Reset values:** hold rst_f = 0, toggle the clock → every output is 0 and busy = 0. Release rst_f → outputs unchanged until a req arrives.
- **Single fetch read:** RD_LAT = 2, mem returns 32'hA5A5_0001 at address 16'h0010, if_req pulsed in cycle 0 → mem_en in cycle 1 with mem_addr = 16'h0010, if_ack and if_rdata = 32'hA5A5_0001 in cycle 4, dm_rdata unchanged.
- **Store:** dm_req, dm_we = 1, dm_addr = 16'h0020, dm_wdata = 32'hDEAD_BEEF → cycle 1 has mem_en = mem_we = 1 with that address and data, dm_ack in cycle 2, both rdata registers unchanged.
- **Collision and starvation:** STARVE = 3, if_req held high, dm_req re-asserted after every ack → grant order is D, D, D, F, D, D, D, F. With if_req low, data is granted indefinitely and starve_cnt stays 0.
- **Reset mid-read:** assert rst_f low during WAIT → immediate IDLE, no ack ever issued for that read. A fresh fetch after release completes with normal latency.
- **RD_LAT sweep:** RD_LAT = 1 and RD_LAT = 7 → read ack in cycle 3 and cycle 9 respectively, with correct data.
